vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised raster timing generator that replaces the fixed 640x480 sync counter.
//  Porch and sync widths are set per axis, sync polarity is selectable, and a pixel clock-enable lets it run from a faster system clock.
//  Drives the sprite/pipe renderer with active-area x/y, plus frame-start, line-start and vblank-start pulses.
//  An internal delay line aligns hsync/vsync/de with the renderer pipeline latency.
// PARAMETERS
//  H_ACTIVE 640 : visible pixels per line
//  H_FP 16 : horizontal front porch, in pixels
//  H_SYNC 96 : hsync width, in pixels
//  H_BP 48 : horizontal back porch, in pixels
//  V_ACTIVE 480 : visible lines per frame
//  V_FP 10 : vertical front porch, in lines
//  V_SYNC 2 : vsync width, in lines
//  V_BP 33 : vertical back porch, in lines
//  H_SYNC_POL 0 : 1 = hsync active-high, 0 = active-low
//  V_SYNC_POL 0 : 1 = vsync active-high, 0 = active-low
//  SYNC_DLY 0 : extra pixel periods (0..15) added to hsync/vsync/de relative to x/y
//  FCW 16 : frame counter width (used only with VGA_FRAME_CNT_EN)
// PORTS
//  clk           in   1     system/pixel clock
//  clr           in   1     synchronous active-high reset
//  pix_ce        in   1     pixel enable; all state advances only when 1
//  hsync         out  1     horizontal sync, polarity per H_SYNC_POL
//  vsync         out  1     vertical sync, polarity per V_SYNC_POL
//  de            out  1     display enable (active area), delayed by SYNC_DLY
//  x             out  XW    active pixel column, XW=$clog2(H_ACTIVE); 0 outside active area
//  y             out  YW    active line, YW=$clog2(V_ACTIVE); 0 outside active area
//  line_start    out  1     pulse while h_cnt==0
//  frame_start   out  1     pulse while h_cnt==0 && v_cnt==0
//  vblank_start  out  1     pulse while h_cnt==0 && v_cnt==V_ACTIVE
//  frame_cnt     out  FCW   frames completed (present only with VGA_FRAME_CNT_EN)
// BEHAVIOUR
//  - Totals: H_TOT = sum of H_*; V_TOT = sum of V_*. Defaults give 800 x 525.
//  - Internal counters: h_cnt in 0..H_TOT-1, v_cnt in 0..V_TOT-1.
//  - Each axis is ordered active, FP, sync, BP.
//  - On an edge with pix_ce=1:
//      h_cnt==H_TOT-1 -> h_cnt=0 and v_cnt increments (v wraps V_TOT-1 -> 0);
//      otherwise h_cnt+1.
//  - pix_ce=0: every counter, output and delay stage holds.
//  - Output stage is registered. Values presented after a ce edge decode the counter state before that edge (1 pixel period latency).
//      act = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
//      hs_act = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
//      vs_act = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]
//  - x/y/pulses come from the first stage.
//  - hsync/vsync/de pass through SYNC_DLY further ce-qualified stages.
//  - Pulses are one pixel period wide: one clk when pix_ce is tied 1.
//  - Reset (clr=1 at an edge) dominates pix_ce:
//      h_cnt=v_cnt=0; x=y=0; de=0; pulses=0;
//      hsync=~H_SYNC_POL, vsync=~V_SYNC_POL (inactive level);
//      all delay stages loaded inactive; frame_cnt=0.
//  - First ce edge after reset presents state (0,0):
//      frame_start=1, line_start=1, x=0, y=0;
//      de=1 only if SYNC_DLY=0.
//  - Reset mid-frame restarts at (0,0) with no partial sync pulse from the delay line.
// CONFIGURATION
//  - VGA_FRAME_CNT_EN defined: frame_cnt port exists.
//      It increments by 1 in the same update that asserts frame_start, except the first frame_start after reset, which leaves it at 0.
//      It wraps 2^FCW-1 -> 0.
//  - VGA_FRAME_CNT_EN undefined: port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  - Package vga_timing_pkg holds:
//      named timing-set constants (640x480@60, 800x600@60);
//      function tot(a,fp,s,bp);
//      polarity constants SYNC_POS/SYNC_NEG.
//  - Sub-module vga_sync_delay: 3-bit-wide ce-gated shift register, depth SYNC_DLY.
//      Synchronous clr loads a parametrised inactive pattern.
//      SYNC_DLY=0 is a pass-through.
// TESTING
//  1. Defaults, pix_ce=1: hsync low exactly 96 clk every 800; vsync low 1600 clk every 420000; de high 640 clk/line, 307200 clk/frame.
//  2. Defaults: x=639,y=479 followed next clk by de=0 and x=0; vblank_start is high 1 clk per frame, 480 lines after frame_start.
//  3. pix_ce 1-in-4 pattern: line period 3200 clk; outputs change only on ce edges; pulses are 4 clk wide.
//  4. SYNC_DLY=3: frame_start (x=0,y=0) at cycle t -> de rises at t+3; hsync falling edge lags the decoded h_cnt=656 by 3 clk.
//  5. H=4/1/2/1, V=3/1/1/1, H_SYNC_POL=1: line period 8 clk; hsync high for 2 clk, at x counts 5..6; frame 48 clk; polarity correct.
//  6. clr asserted for 1 clk mid-line at h_cnt=300 (and with pix_ce=0): next edge gives all outputs inactive; frame_start 1 ce later; with VGA_FRAME_CNT_EN, frame_cnt=0, then 1 after a full frame.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the raster timing generator.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
// Contents: named timing sets (640x480@60, 800x600@60), tot() for per-axis totals,
//           and SYNC_POS/SYNC_NEG polarity constants.
package vga_timing_pkg;

    localparam bit SYNC_POS = 1'b1;
    localparam bit SYNC_NEG = 1'b0;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock, both syncs negative
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;
    localparam bit VGA640_H_POL    = SYNC_NEG;
    localparam bit VGA640_V_POL    = SYNC_NEG;

    // 800x600 @ 60 Hz, 40 MHz pixel clock, both syncs positive
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;
    localparam bit SVGA800_H_POL    = SYNC_POS;
    localparam bit SVGA800_V_POL    = SYNC_POS;

    // Total period of one axis: active + front porch + sync + back porch
    function automatic int tot(input int a, input int fp, input int s, input int bp);
        return a + fp + s + bp;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Retimes {hsync, vsync, de} by DEPTH pixel periods to match the renderer pipeline.
// Latency: DEPTH pixel-enabled clocks; DEPTH=0 is a combinational pass-through.
// Backpressure: none; stages shift only when ce=1, clr loads INIT into every stage.
// Ports: clk, clr (sync active-high), ce (pixel enable), d[2:0] in, q[2:0] out.
module vga_sync_delay #(
    parameter int         DEPTH = 0,
    parameter logic [2:0] INIT  = 3'b000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ce,
    input  logic [2:0] d,
    output logic [2:0] q
);

    // At least one stage is declared so DEPTH=0 elaborates; it is bypassed at q.
    localparam int NS = (DEPTH == 0) ? 1 : DEPTH;

    logic [2:0] sr [NS];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NS; i++) sr[i] <= INIT;
        end else if (ce) begin
            sr[0] <= d;
            for (int i = 1; i < NS; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = (DEPTH == 0) ? d : sr[NS-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: h/v counters, active x/y, line/frame/vblank pulses.
// Latency: x/y/pulses 1 pixel period after the counter state; hsync/vsync/de 1+SYNC_DLY.
// Backpressure: none; everything holds while pix_ce=0, clr dominates pix_ce.
// Ports: clk, clr, pix_ce in; hsync, vsync, de, x, y, line_start, frame_start,
//        vblank_start out; frame_cnt out only when VGA_FRAME_CNT_EN is defined.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int  H_ACTIVE   = VGA640_H_ACTIVE,
    parameter int  H_FP       = VGA640_H_FP,
    parameter int  H_SYNC     = VGA640_H_SYNC,
    parameter int  H_BP       = VGA640_H_BP,
    parameter int  V_ACTIVE   = VGA640_V_ACTIVE,
    parameter int  V_FP       = VGA640_V_FP,
    parameter int  V_SYNC     = VGA640_V_SYNC,
    parameter int  V_BP       = VGA640_V_BP,
    parameter bit  H_SYNC_POL = VGA640_H_POL,
    parameter bit  V_SYNC_POL = VGA640_V_POL,
    parameter int  SYNC_DLY   = 0,
    parameter int  FCW        = 16,
    localparam int XW         = $clog2(H_ACTIVE),
    localparam int YW         = $clog2(V_ACTIVE)
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           pix_ce,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic [XW-1:0]  x,
    output logic [YW-1:0]  y,
    output logic           line_start,
    output logic           frame_start,
    output logic           vblank_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [FCW-1:0] frame_cnt
`endif
);

    localparam int H_TOT  = tot(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT  = tot(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HCW    = $clog2(H_TOT);
    localparam int VCW    = $clog2(V_TOT);
    localparam int HS_BEG = H_ACTIVE + H_FP;
    localparam int HS_LST = HS_BEG + H_SYNC - 1;
    localparam int VS_BEG = V_ACTIVE + V_FP;
    localparam int VS_LST = VS_BEG + V_SYNC - 1;

    // Bit order through the delay line is {hsync, vsync, de}; idle is inactive sync, de low
    localparam logic [2:0] SYNC_IDLE = {~H_SYNC_POL, ~V_SYNC_POL, 1'b0};

    logic [HCW-1:0] h_cnt;
    logic [VCW-1:0] v_cnt;
    logic           h_last;
    logic           v_last;
    logic           act;
    logic           hs_act;
    logic           vs_act;
    logic           at_origin;
    logic [2:0]     sync_s1;
    logic [2:0]     sync_out;

    always_comb begin
        h_last    = (h_cnt == HCW'(H_TOT - 1));
        v_last    = (v_cnt == VCW'(V_TOT - 1));
        act       = (h_cnt < HCW'(H_ACTIVE)) && (v_cnt < VCW'(V_ACTIVE));
        hs_act    = (h_cnt >= HCW'(HS_BEG)) && (h_cnt <= HCW'(HS_LST));
        vs_act    = (v_cnt >= VCW'(VS_BEG)) && (v_cnt <= VCW'(VS_LST));
        at_origin = (h_cnt == '0) && (v_cnt == '0);
    end

    // Raster position counters
    always_ff @(posedge clk) begin
        if (clr) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + VCW'(1);
            end else begin
                h_cnt <= h_cnt + HCW'(1);
            end
        end
    end

    // First output stage: decodes the counter state present before this ce edge
    always_ff @(posedge clk) begin
        if (clr) begin
            x            <= '0;
            y            <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            sync_s1      <= SYNC_IDLE;
        end else if (pix_ce) begin
            x            <= act ? h_cnt[XW-1:0] : '0;
            y            <= act ? v_cnt[YW-1:0] : '0;
            line_start   <= (h_cnt == '0);
            frame_start  <= at_origin;
            vblank_start <= (h_cnt == '0) && (v_cnt == VCW'(V_ACTIVE));
            sync_s1      <= {hs_act ? H_SYNC_POL : ~H_SYNC_POL,
                             vs_act ? V_SYNC_POL : ~V_SYNC_POL,
                             act};
        end
    end

    vga_sync_delay #(
        .DEPTH (SYNC_DLY),
        .INIT  (SYNC_IDLE)
    ) u_sync_delay (
        .clk (clk),
        .clr (clr),
        .ce  (pix_ce),
        .d   (sync_s1),
        .q   (sync_out)
    );

    assign {hsync, vsync, de} = sync_out;

`ifdef VGA_FRAME_CNT_EN
    // The first frame_start after reset only arms the counter, so frame_cnt counts
    // completed frames rather than frame starts.
    logic fc_armed;

    always_ff @(posedge clk) begin
        if (clr) begin
            frame_cnt <= '0;
            fc_armed  <= 1'b0;
        end else if (pix_ce && at_origin) begin
            if (fc_armed) frame_cnt <= frame_cnt + FCW'(1);
            fc_armed <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    // Instance 0: defaults; 1: defaults with SYNC_DLY=3; 2: tiny raster, active-high hsync;
    // 3: medium raster, active-high vsync, SYNC_DLY=2.
    localparam int N = 4;
    localparam int HA [N] = '{640, 640, 4, 16};
    localparam int HF [N] = '{16, 16, 1, 4};
    localparam int HS [N] = '{96, 96, 2, 6};
    localparam int HB [N] = '{48, 48, 1, 4};
    localparam int VA [N] = '{480, 480, 3, 10};
    localparam int VF [N] = '{10, 10, 1, 2};
    localparam int VS [N] = '{2, 2, 1, 3};
    localparam int VB [N] = '{33, 33, 1, 5};
    localparam bit HP [N] = '{1'b0, 1'b0, 1'b1, 1'b0};
    localparam bit VP [N] = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam int DL [N] = '{0, 3, 0, 2};
    localparam int FW [N] = '{16, 16, 3, 4};

    typedef struct packed {
        logic hs; logic vs; logic de; int x; int y;
        logic ls; logic fs; logic vb; int fc;
    } obs_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic pix_ce = 1'b0;

    logic [N-1:0] hs_w, vs_w, de_w, ls_w, fs_w, vb_w;
    logic [9:0] x0, x1;
    logic [8:0] y0, y1;
    logic [1:0] x2, y2;
    logic [3:0] x3, y3;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fc0, fc1;
    logic [2:0]  fc2;
    logic [3:0]  fc3;
`endif

    obs_t obs [N];
    int   kce = 0;    // ce edges since last reset
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(.SYNC_DLY(DL[0]), .FCW(FW[0])) dut0 (
        .clk(clk), .clr(clr), .pix_ce(pix_ce), .hsync(hs_w[0]), .vsync(vs_w[0]), .de(de_w[0]),
        .x(x0), .y(y0), .line_start(ls_w[0]), .frame_start(fs_w[0]), .vblank_start(vb_w[0])
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc0)
`endif
    );

    vga_timing_gen #(.SYNC_DLY(DL[1]), .FCW(FW[1])) dut1 (
        .clk(clk), .clr(clr), .pix_ce(pix_ce), .hsync(hs_w[1]), .vsync(vs_w[1]), .de(de_w[1]),
        .x(x1), .y(y1), .line_start(ls_w[1]), .frame_start(fs_w[1]), .vblank_start(vb_w[1])
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc1)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(HA[2]), .H_FP(HF[2]), .H_SYNC(HS[2]), .H_BP(HB[2]),
        .V_ACTIVE(VA[2]), .V_FP(VF[2]), .V_SYNC(VS[2]), .V_BP(VB[2]),
        .H_SYNC_POL(HP[2]), .V_SYNC_POL(VP[2]), .SYNC_DLY(DL[2]), .FCW(FW[2])
    ) dut2 (
        .clk(clk), .clr(clr), .pix_ce(pix_ce), .hsync(hs_w[2]), .vsync(vs_w[2]), .de(de_w[2]),
        .x(x2), .y(y2), .line_start(ls_w[2]), .frame_start(fs_w[2]), .vblank_start(vb_w[2])
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc2)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(HA[3]), .H_FP(HF[3]), .H_SYNC(HS[3]), .H_BP(HB[3]),
        .V_ACTIVE(VA[3]), .V_FP(VF[3]), .V_SYNC(VS[3]), .V_BP(VB[3]),
        .H_SYNC_POL(HP[3]), .V_SYNC_POL(VP[3]), .SYNC_DLY(DL[3]), .FCW(FW[3])
    ) dut3 (
        .clk(clk), .clr(clr), .pix_ce(pix_ce), .hsync(hs_w[3]), .vsync(vs_w[3]), .de(de_w[3]),
        .x(x3), .y(y3), .line_start(ls_w[3]), .frame_start(fs_w[3]), .vblank_start(vb_w[3])
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc3)
`endif
    );

    always_comb begin
        obs[0] = '{hs_w[0], vs_w[0], de_w[0], int'(x0), int'(y0), ls_w[0], fs_w[0], vb_w[0], 0};
        obs[1] = '{hs_w[1], vs_w[1], de_w[1], int'(x1), int'(y1), ls_w[1], fs_w[1], vb_w[1], 0};
        obs[2] = '{hs_w[2], vs_w[2], de_w[2], int'(x2), int'(y2), ls_w[2], fs_w[2], vb_w[2], 0};
        obs[3] = '{hs_w[3], vs_w[3], de_w[3], int'(x3), int'(y3), ls_w[3], fs_w[3], vb_w[3], 0};
`ifdef VGA_FRAME_CNT_EN
        obs[0].fc = int'(fc0);
        obs[1].fc = int'(fc1);
        obs[2].fc = int'(fc2);
        obs[3].fc = int'(fc3);
`endif
    end

    // Reference: after k ce edges the first stage shows linear pixel index k-1 of the
    // raster, the sync/de outputs show index k-1-SYNC_DLY; anything earlier is idle.
    function automatic obs_t model(input int i, input int k);
        obs_t m;
        int ht, vt, ft, p, h, v;
        ht = HA[i] + HF[i] + HS[i] + HB[i];
        vt = VA[i] + VF[i] + VS[i] + VB[i];
        ft = ht * vt;
        m = '{~HP[i], ~VP[i], 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0};
        if (k >= 1) begin
            p = (k - 1) % ft;
            h = p % ht;
            v = p / ht;
            if (h < HA[i] && v < VA[i]) begin
                m.x = h;
                m.y = v;
            end
            m.ls = (h == 0);
            m.fs = (p == 0);
            m.vb = (h == 0 && v == VA[i]);
`ifdef VGA_FRAME_CNT_EN
            m.fc = ((k - 1) / ft) % (1 << FW[i]);
`endif
        end
        if (k - 1 - DL[i] >= 0) begin
            p = (k - 1 - DL[i]) % ft;
            h = p % ht;
            v = p / ht;
            m.de = (h < HA[i] && v < VA[i]);
            m.hs = (h >= HA[i] + HF[i] && h < HA[i] + HF[i] + HS[i]) ? HP[i] : ~HP[i];
            m.vs = (v >= VA[i] + VF[i] && v < VA[i] + VF[i] + VS[i]) ? VP[i] : ~VP[i];
        end
        return m;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b vb=%b fc=%0d",
                         o.hs, o.vs, o.de, o.x, o.y, o.ls, o.fs, o.vb, o.fc);
    endfunction

    // One clock: drive inputs at the falling edge, return at the next falling edge
    task automatic tick(input logic ce, input logic rst);
        pix_ce = ce;
        clr    = rst;
        @(posedge clk);
        @(negedge clk);
        if (rst) kce = 0;
        else if (ce) kce++;
    endtask

    task automatic test_reset();
        obs_t e;
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        for (int i = 0; i < N; i++) begin
            e = model(i, kce);
            checks++;
            if (obs[i] !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got %s, want %s", i, fmt(obs[i]), fmt(e));
            end
        end
        checks++;
        if (hs_w !== 4'b1011 || vs_w !== 4'b0111 || de_w !== 4'b0000) begin
            errors++;
            $display("FAIL reset_levels: hs=%b vs=%b de=%b, want hs=1011 vs=0111 de=0000",
                     hs_w, vs_w, de_w);
        end
    endtask

    task automatic test_first_edge();
        obs_t e;
        tick(1'b1, 1'b0);
        checks++;
        if ({fs_w[0], ls_w[0], de_w[0]} !== 3'b111 || x0 !== 10'd0 || y0 !== 9'd0) begin
            errors++;
            $display("FAIL first_edge_d0: fs/ls/de=%b x=%0d y=%0d, want 111 x=0 y=0",
                     {fs_w[0], ls_w[0], de_w[0]}, x0, y0);
        end
        checks++;
        if (de_w[1] !== 1'b0 || fs_w[1] !== 1'b1) begin
            errors++;
            $display("FAIL first_edge_dly3: de=%b fs=%b, want de=0 fs=1", de_w[1], fs_w[1]);
        end
        for (int i = 0; i < N; i++) begin
            e = model(i, kce);
            checks++;
            if (obs[i] !== e) begin
                errors++;
                $display("FAIL first_edge[%0d]: got %s, want %s", i, fmt(obs[i]), fmt(e));
            end
        end
    endtask

    task automatic test_sync_delay();
        int   fs0_t, de1_t, hf0_t, hf1_t;
        logic p_de1, p_hs0, p_hs1;
        fs0_t = -1; de1_t = -1; hf0_t = -1; hf1_t = -1;
        tick(1'b1, 1'b1);
        p_de1 = de_w[1]; p_hs0 = hs_w[0]; p_hs1 = hs_w[1];
        for (int t = 1; t <= 900; t++) begin
            tick(1'b1, 1'b0);
            if (fs0_t < 0 && fs_w[0] && x0 == 10'd0 && y0 == 9'd0) fs0_t = t;
            if (de1_t < 0 && de_w[1] && !p_de1) de1_t = t;
            if (hf0_t < 0 && !hs_w[0] && p_hs0) hf0_t = t;
            if (hf1_t < 0 && !hs_w[1] && p_hs1) hf1_t = t;
            p_de1 = de_w[1]; p_hs0 = hs_w[0]; p_hs1 = hs_w[1];
        end
        checks++;
        if (fs0_t != 1 || de1_t != fs0_t + 3) begin
            errors++;
            $display("FAIL dly_de_rise: frame_start at %0d, delayed de rise at %0d, want 1 and 4",
                     fs0_t, de1_t);
        end
        checks++;
        if (hf0_t != 657) begin
            errors++;
            $display("FAIL hsync_fall_pos: at clk %0d, want 657 (h_cnt 656)", hf0_t);
        end
        checks++;
        if (hf1_t != hf0_t + 3) begin
            errors++;
            $display("FAIL dly_hsync_fall: delayed fall at %0d, undelayed at %0d, want lag 3",
                     hf1_t, hf0_t);
        end
    endtask

    task automatic test_line_timing();
        int   hs_low, de_hi, wraps, f1, f2;
        logic p_hs, p_de;
        int   p_x;
        hs_low = 0; de_hi = 0; wraps = 0; f1 = -1; f2 = -1;
        tick(1'b1, 1'b1);
        p_hs = hs_w[0]; p_de = de_w[0]; p_x = int'(x0);
        for (int t = 1; t <= 1600; t++) begin
            tick(1'b1, 1'b0);
            if (!hs_w[0]) hs_low++;
            if (de_w[0]) de_hi++;
            if (p_hs && !hs_w[0]) begin
                if (f1 < 0) f1 = t;
                else if (f2 < 0) f2 = t;
            end
            if (p_de && p_x == 639 && !de_w[0] && x0 == 10'd0) wraps++;
            p_hs = hs_w[0]; p_de = de_w[0]; p_x = int'(x0);
        end
        checks++;
        if (hs_low != 192) begin
            errors++;
            $display("FAIL hsync_low_count: %0d clk over two lines, want 192", hs_low);
        end
        checks++;
        if (de_hi != 1280) begin
            errors++;
            $display("FAIL de_high_count: %0d clk over two lines, want 1280", de_hi);
        end
        checks++;
        if (f2 - f1 != 800) begin
            errors++;
            $display("FAIL hsync_period: %0d clk, want 800", f2 - f1);
        end
        checks++;
        if (wraps != 2) begin
            errors++;
            $display("FAIL x639_to_blank: %0d transitions, want 2", wraps);
        end
    endtask

    task automatic test_frame_timing();
        int fs_t [$];
        int vb_t [$];
        int vs_act, de_hi;
        vs_act = 0; de_hi = 0;
        tick(1'b1, 1'b1);
        for (int t = 1; t <= 1200; t++) begin
            tick(1'b1, 1'b0);
            if (fs_w[3]) fs_t.push_back(t);
            if (vb_w[3]) vb_t.push_back(t);
            if (vs_w[3]) vs_act++;
            if (de_w[3]) de_hi++;
        end
        checks++;
        if (fs_t.size() != 2 || vb_t.size() != 2) begin
            errors++;
            $display("FAIL pulse_counts: frame_start %0d, vblank_start %0d, want 2 and 2",
                     fs_t.size(), vb_t.size());
        end else begin
            checks++;
            if (fs_t[1] - fs_t[0] != 600) begin
                errors++;
                $display("FAIL frame_period: %0d clk, want 600", fs_t[1] - fs_t[0]);
            end
            checks++;
            if (vb_t[0] - fs_t[0] != 300) begin
                errors++;
                $display("FAIL vblank_offset: %0d clk after frame_start, want 300",
                         vb_t[0] - fs_t[0]);
            end
        end
        checks++;
        if (vs_act != 180 || de_hi != 320) begin
            errors++;
            $display("FAIL medium_sync_de: vsync active %0d de %0d, want 180 and 320",
                     vs_act, de_hi);
        end
    endtask

    task automatic test_small_cfg();
        int ls1, ls2, fs1, fs2, hs_hi, hs_bad, de_hi;
        ls1 = -1; ls2 = -1; fs1 = -1; fs2 = -1; hs_hi = 0; hs_bad = 0; de_hi = 0;
        tick(1'b1, 1'b1);
        for (int t = 1; t <= 96; t++) begin
            tick(1'b1, 1'b0);
            if (ls_w[2]) begin
                if (ls1 < 0) ls1 = t;
                else if (ls2 < 0) ls2 = t;
            end
            if (fs_w[2]) begin
                if (fs1 < 0) fs1 = t;
                else if (fs2 < 0) fs2 = t;
            end
            if (hs_w[2]) begin
                hs_hi++;
                if ((kce - 1) % 8 != 5 && (kce - 1) % 8 != 6) hs_bad++;
            end
            if (de_w[2]) de_hi++;
        end
        checks++;
        if (ls2 - ls1 != 8 || fs2 - fs1 != 48) begin
            errors++;
            $display("FAIL small_periods: line %0d frame %0d, want 8 and 48", ls2 - ls1, fs2 - fs1);
        end
        checks++;
        if (hs_hi != 24 || hs_bad != 0) begin
            errors++;
            $display("FAIL small_hsync: high %0d clk (%0d misplaced), want 24 (0)", hs_hi, hs_bad);
        end
        checks++;
        if (de_hi != 24) begin
            errors++;
            $display("FAIL small_de: %0d clk, want 24", de_hi);
        end
    endtask

    task automatic test_ce_quarter();
        obs_t prev [N];
        int   r1, r2, w1, run, changed;
        logic p_ls;
        r1 = -1; r2 = -1; w1 = -1; run = 0; changed = 0;
        tick(1'b1, 1'b1);
        p_ls = ls_w[0];
        for (int i = 0; i < N; i++) prev[i] = obs[i];
        for (int c = 0; c < 3400; c++) begin
            tick(c % 4 == 0, 1'b0);
            if (c % 4 != 0) begin
                for (int i = 0; i < N; i++) if (obs[i] !== prev[i]) changed++;
            end
            if (ls_w[0] && !p_ls) begin
                if (r1 < 0) r1 = c;
                else if (r2 < 0) r2 = c;
            end
            if (ls_w[0]) run++;
            if (!ls_w[0] && p_ls && w1 < 0) w1 = run;
            if (!ls_w[0]) run = 0;
            p_ls = ls_w[0];
            for (int i = 0; i < N; i++) prev[i] = obs[i];
        end
        checks++;
        if (r2 - r1 != 3200) begin
            errors++;
            $display("FAIL ce_line_period: %0d clk, want 3200", r2 - r1);
        end
        checks++;
        if (w1 != 4) begin
            errors++;
            $display("FAIL ce_pulse_width: line_start %0d clk wide, want 4", w1);
        end
        checks++;
        if (changed != 0) begin
            errors++;
            $display("FAIL ce_hold: %0d output changes on non-ce edges, want 0", changed);
        end
    endtask

    task automatic test_mid_reset();
        obs_t e;
        tick(1'b1, 1'b1);
        for (int t = 0; t < 300; t++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        checks++;
        if (hs_w !== 4'b1011 || vs_w !== 4'b0111 || de_w !== 4'b0000 ||
            ls_w !== 4'b0000 || fs_w !== 4'b0000 || vb_w !== 4'b0000 ||
            x0 !== 10'd0 || y0 !== 9'd0) begin
            errors++;
            $display("FAIL mid_reset_idle: hs=%b vs=%b de=%b ls=%b fs=%b vb=%b x=%0d y=%0d",
                     hs_w, vs_w, de_w, ls_w, fs_w, vb_w, x0, y0);
        end
        tick(1'b1, 1'b0);
        checks++;
        if (fs_w !== 4'b1111) begin
            errors++;
            $display("FAIL mid_reset_restart: frame_start=%b, want 1111", fs_w);
        end
        for (int i = 0; i < N; i++) begin
            e = model(i, kce);
            checks++;
            if (obs[i] !== e) begin
                errors++;
                $display("FAIL mid_reset[%0d]: got %s, want %s", i, fmt(obs[i]), fmt(e));
            end
        end
`ifdef VGA_FRAME_CNT_EN
        checks++;
        if (fc2 !== 3'd0) begin
            errors++;
            $display("FAIL frame_cnt_first: %0d, want 0", fc2);
        end
        for (int t = 0; t < 48; t++) tick(1'b1, 1'b0);
        checks++;
        if (fc2 !== 3'd1 || fs_w[2] !== 1'b1) begin
            errors++;
            $display("FAIL frame_cnt_second: cnt=%0d fs=%b, want 1 and 1", fc2, fs_w[2]);
        end
`endif
    endtask

    task automatic test_random_ce();
        obs_t e;
        logic ce, rst;
        tick(1'b1, 1'b1);
        for (int t = 0; t < 4000; t++) begin
            ce  = ($urandom_range(0, 9) < 6);
            rst = ($urandom_range(0, 699) == 0);
            tick(ce, rst);
            for (int i = 0; i < N; i++) begin
                e = model(i, kce);
                checks++;
                if (obs[i] !== e) begin
                    errors++;
                    $display("FAIL random[%0d] k=%0d: got %s, want %s", i, kce, fmt(obs[i]), fmt(e));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_edge();
        test_sync_delay();
        test_line_timing();
        test_frame_timing();
        test_small_cfg();
        test_ce_quarter();
        test_mid_reset();
        test_random_ce();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
